// File: rtl/uart_fifo_if.sv
// Handshake bundle between a uart_fifo and the logic that pushes/pops it.
// The slave modport is the FIFO itself; the master modport is its user.
interface uart_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
);
  logic              flush_i;
  logic              push_i;
  logic [DATA_W-1:0] push_data_i;
  logic              pop_i;
  logic [DATA_W-1:0] pop_data_o;
  logic              full_o;
  logic              empty_o;
  logic [ADDR_W:0]   count_o;
  logic              overflow_o;
  logic              underflow_o;

  modport slave (
    input  flush_i, push_i, push_data_i, pop_i,
    output pop_data_o, full_o, empty_o, count_o, overflow_o, underflow_o
  );

  modport master (
    output flush_i, push_i, push_data_i, pop_i,
    input  pop_data_o, full_o, empty_o, count_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/uart_fifo.sv
// First-word-fall-through FIFO for the UART data path (one per direction).
// Head word is visible combinationally from registered state; occupancy and
// sticky overflow/underflow flags are exported for status reporting.
module uart_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  uart_fifo_if.slave   bus
);

  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              full, empty;
  logic              push_acc, pop_acc, wr_en;

  // Full/empty come straight from the registered pointers: the extra wrap
  // bit distinguishes "same slot, one lap apart" (full) from "equal" (empty).
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

  // A push into a full FIFO is fine when the head leaves in the same cycle;
  // a pop from an empty FIFO never succeeds, even alongside a push.
  assign pop_acc  = bus.pop_i && !empty;
  assign push_acc = bus.push_i && (!full || bus.pop_i);
  assign wr_en    = push_acc && !bus.flush_i;

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.flush_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_acc)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + PTR_ONE;
        2'b01:   count_d = count_q - PTR_ONE;
        default: count_d = count_q;
      endcase
      if (bus.push_i && !push_acc) overflow_d  = 1'b1;
      if (bus.pop_i  && !pop_acc)  underflow_d = 1'b1;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage write port.
  always_ff @(posedge clk_i) begin
    // NOTE: the memory has no reset; empty_o guards stale contents and this keeps it mappable to RAM.
    if (wr_en && !rst_i) mem_q[wr_ptr_q[ADDR_W-1:0]] <= bus.push_data_i;
  end

  assign bus.pop_data_o  = empty ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign bus.full_o      = full;
  assign bus.empty_o     = empty;
  assign bus.count_o     = count_q;
  assign bus.overflow_o  = overflow_q;
  assign bus.underflow_o = underflow_q;

endmodule
